perceptron_sample_loader: RTL

//  Upstream feeder for the perceptron trainer. Captures a training set byte-serially from the pad inputs into
//  an internal sample buffer, then replays it sample-by-sample over a valid/ready stream for a programmable

---
 rtl/perceptron_sample_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/perceptron_sample_loader.sv
// Byte-serial training-set loader that replays its buffer over a valid/ready stream for N epochs.
// Optional LOADER_CHECKSUM_EN adds a running mod-2^DW byte checksum output.
module perceptron_sample_loader #(
  parameter int N_SAMPLES = 3,
  parameter int INP_DIM   = 2,
  parameter int DW        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  in_ready,
  input  logic                  reload,
  input  logic                  start,
  input  logic [3:0]            epochs,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INP_DIM*DW-1:0] out_x,
  output logic                  out_y,
  output logic                  out_last,
  output logic                  out_last_ep,
  output logic                  busy,
  output logic                  loaded
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DW-1:0]         checksum
`endif
);

  localparam int SB    = INP_DIM + 1;
  localparam int TOTAL = N_SAMPLES * SB;
  localparam int WPW   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SW    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM} state_e;

  state_e         state_q, state_d;
  logic [WPW-1:0] wptr_q, wptr_d;
  logic [SW-1:0]  sidx_q, sidx_d;
  logic [3:0]     eidx_q, eidx_d;
  logic [3:0]     etgt_q, etgt_d;
  logic [DW-1:0]  buf_q [TOTAL];
  logic           accept, hs, last_s, last_e;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0]  csum_q, csum_d;
`endif

  assign accept = (state_q == S_LOAD) && in_valid;
  assign hs     = (state_q == S_STREAM) && out_ready;
  assign last_s = (sidx_q == SW'(N_SAMPLES - 1));
  assign last_e = (eidx_q == (etgt_q - 4'd1));

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    sidx_d  = sidx_q;
    eidx_d  = eidx_q;
    etgt_d  = etgt_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    // reload pre-empts everything, including a same-cycle start or stream handshake
    if (reload) begin
      state_d = S_LOAD;
      wptr_d  = '0;
      sidx_d  = '0;
      eidx_d  = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        S_LOAD: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (wptr_q == WPW'(TOTAL - 1)) begin
            wptr_d  = '0;
            state_d = S_READY;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
        S_READY: if (start) begin
          state_d = S_STREAM;
          sidx_d  = '0;
          eidx_d  = '0;
          etgt_d  = (epochs == 4'd0) ? 4'd1 : epochs;
        end
        S_STREAM: if (hs) begin
          if (last_s) begin
            sidx_d = '0;
            if (last_e) state_d = S_READY;
            else        eidx_d  = eidx_q + 4'd1;
          end else begin
            sidx_d = sidx_q + 1'b1;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      wptr_q  <= '0;
      sidx_q  <= '0;
      eidx_q  <= '0;
      etgt_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      sidx_q  <= sidx_d;
      eidx_q  <= eidx_d;
      etgt_q  <= etgt_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Sample storage is datapath only: never reset, contents meaningless until a full load completes.
  always_ff @(posedge clk) begin
    if (accept) buf_q[wptr_q] <= in_data;
  end

  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_STREAM);
  assign busy        = (state_q == S_STREAM);
  assign loaded      = (state_q == S_READY);
  assign out_last    = out_valid && last_s;
  assign out_last_ep = out_valid && last_e;

  for (genvar g = 0; g < INP_DIM; g++) begin : g_feat
    logic [WPW-1:0] ridx;
    assign ridx = WPW'(sidx_q) * WPW'(SB) + WPW'(g);
    assign out_x[g*DW +: DW] = out_valid ? buf_q[ridx] : '0;
  end

  logic [WPW-1:0] lidx;
  assign lidx  = WPW'(sidx_q) * WPW'(SB) + WPW'(INP_DIM);
  assign out_y = out_valid && buf_q[lidx][0];

`ifdef LOADER_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule
